slurm32_cpu_memory_access: RTL

- Memory-access responder that sits between the execute stage and the data bus.
- Accepts the execute stage's single-cycle load/store request (load_memory, store_memory, word address, data, byte mask) and runs one outstanding transaction on a valid/ready data bus.
- Stalls the pipeline while the transaction is in flight.
- For loads, returns lane-extracted, optionally sign-extended data to writeback, tagged with the destination register.

---
 rtl/slurm32_cpu_memory_access_if.sv | 35 +++
 rtl/slurm32_cpu_memory_access.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/slurm32_cpu_memory_access_if.sv
// Data-bus interface between the memory-access stage and the data memory.
// One outstanding request at a time: the master holds mem_valid with a
// stable address/data/mask until the slave answers with mem_ready; read data
// comes back on mem_rvalid, either together with mem_ready or later.
//   mem_addr   : word address (ADDRESS_BITS-2 bits)
//   mem_wdata  : write data, lanes already positioned by the execute stage
//   mem_wmask  : write byte enables
//   mem_valid  : request valid
//   mem_wr     : 1 = write, 0 = read
//   mem_ready  : slave accepts the request
//   mem_rdata  : read data
//   mem_rvalid : read data valid
interface slurm32_cpu_memory_access_if #(
    parameter int BITS         = 32,
    parameter int ADDRESS_BITS = 32
);
    logic [ADDRESS_BITS-3:0] mem_addr;
    logic [BITS-1:0]         mem_wdata;
    logic [3:0]              mem_wmask;
    logic                    mem_valid;
    logic                    mem_wr;
    logic                    mem_ready;
    logic [BITS-1:0]         mem_rdata;
    logic                    mem_rvalid;

    modport master (
        output mem_addr, mem_wdata, mem_wmask, mem_valid, mem_wr,
        input  mem_ready, mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wmask, mem_valid, mem_wr,
        output mem_ready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/slurm32_cpu_memory_access.sv
// Memory-access stage of the slurm32 pipeline. Takes a single-cycle
// load/store request from execute, runs it as one transaction on the data
// bus, stalls execute while the transaction is in flight, and hands load
// results (lane-extracted, optionally sign-extended) to writeback with the
// destination register tag. A transaction that spends TIMEOUT_CYCLES in
// REQ+RDATA is aborted with a one-cycle bus_error pulse.
// Ports:
//   CLK, RSTb          : clock, synchronous active-low reset
//   load_memory        : load request from execute
//   store_memory       : store request from execute (wins if both set)
//   load_store_address : word address
//   memory_out         : store data
//   memory_mask        : byte-lane mask
//   load_signed        : sign-extend byte/halfword loads
//   dest_reg           : load destination register
//   stall              : hold the execute stage
//   load_data          : formatted load result (held between pulses)
//   load_data_valid    : one-cycle pulse, load result valid
//   load_dest_reg      : tag for load_data (held between pulses)
//   bus_error          : one-cycle pulse on timeout
//   bus                : data-bus master port
module slurm32_cpu_memory_access #(
    parameter int REGISTER_BITS  = 4,
    parameter int BITS           = 32,
    parameter int ADDRESS_BITS   = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RSTb,
    input  logic                      load_memory,
    input  logic                      store_memory,
    input  logic [ADDRESS_BITS-3:0]   load_store_address,
    input  logic [BITS-1:0]           memory_out,
    input  logic [3:0]                memory_mask,
    input  logic                      load_signed,
    input  logic [REGISTER_BITS-1:0]  dest_reg,
    output logic                      stall,
    output logic [BITS-1:0]           load_data,
    output logic                      load_data_valid,
    output logic [REGISTER_BITS-1:0]  load_dest_reg,
    output logic                      bus_error,
    slurm32_cpu_memory_access_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;

    state_t                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [ADDRESS_BITS-3:0]    addr_q;
    logic [BITS-1:0]            wdata_q;
    logic [3:0]                 mask_q;
    logic                       signed_q;
    logic [REGISTER_BITS-1:0]   dest_q;
    logic                       is_store_q;
    logic                       err_q;
    logic [BITS-1:0]            load_data_q;
    logic [REGISTER_BITS-1:0]   load_dest_reg_q;

    // Right-justify the lane selected by the mask, then zero/sign extend.
    // Masks that are not a single byte or an aligned halfword return the
    // full word untouched.
    function automatic logic [BITS-1:0] format_load(
        input logic [3:0]      mask,
        input logic            sgn,
        input logic [BITS-1:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [BITS-1:0] r;
        r = rdata;
        b = 8'h00;
        h = 16'h0000;
        case (mask)
            4'b0001: begin b = rdata[7:0];   r = {{(BITS-8){sgn & b[7]}}, b}; end
            4'b0010: begin b = rdata[15:8];  r = {{(BITS-8){sgn & b[7]}}, b}; end
            4'b0100: begin b = rdata[23:16]; r = {{(BITS-8){sgn & b[7]}}, b}; end
            4'b1000: begin b = rdata[31:24]; r = {{(BITS-8){sgn & b[7]}}, b}; end
            4'b0011: begin h = rdata[15:0];  r = {{(BITS-16){sgn & h[15]}}, h}; end
            4'b1100: begin h = rdata[31:16]; r = {{(BITS-16){sgn & h[15]}}, h}; end
            default: r = rdata;
        endcase
        return r;
    endfunction

    logic timeout;
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            mask_q          <= '0;
            signed_q        <= 1'b0;
            dest_q          <= '0;
            is_store_q      <= 1'b0;
            err_q           <= 1'b0;
            load_data_q     <= '0;
            load_dest_reg_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_memory || store_memory) begin
                        addr_q     <= load_store_address;
                        wdata_q    <= memory_out;
                        mask_q     <= memory_mask;
                        signed_q   <= load_signed;
                        dest_q     <= dest_reg;
                        is_store_q <= store_memory;
                        cnt_q      <= '0;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Completion this cycle takes priority over the timeout.
                    if (bus.mem_ready && is_store_q) begin
                        state_q <= DONE;
                    end else if (bus.mem_ready && bus.mem_rvalid) begin
                        load_data_q     <= format_load(mask_q, signed_q, bus.mem_rdata);
                        load_dest_reg_q <= dest_q;
                        state_q         <= DONE;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                        if (!is_store_q) begin
                            load_data_q     <= '0;
                            load_dest_reg_q <= dest_q;
                        end
                    end else if (bus.mem_ready) begin
                        state_q <= RDATA;
                    end
                end
                RDATA: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (bus.mem_rvalid) begin
                        load_data_q     <= format_load(mask_q, signed_q, bus.mem_rdata);
                        load_dest_reg_q <= dest_q;
                        state_q         <= DONE;
                    end else if (timeout) begin
                        err_q           <= 1'b1;
                        load_data_q     <= '0;
                        load_dest_reg_q <= dest_q;
                        state_q         <= DONE;
                    end
                end
                // Execute still presents the finished request here; ignore it.
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall = (state_q == REQ) || (state_q == RDATA) ||
                   ((state_q == IDLE) && (load_memory || store_memory));

    assign load_data_valid = (state_q == DONE) && !is_store_q;
    assign load_data       = load_data_q;
    assign load_dest_reg   = load_dest_reg_q;
    assign bus_error       = err_q;

    assign bus.mem_valid = (state_q == REQ);
    assign bus.mem_wr    = is_store_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = mask_q;

endmodule
